// File: rtl/otter_br_resolve_unit_pkg.sv
// Shared branch-resolution definitions: RV32I branch funct3 encodings, instruction size,
// and the funct3-to-direction decode used by the resolve unit.
package otter_br_resolve_unit_pkg;

  localparam logic [2:0] FUNCT3_B_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_B_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_B_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_B_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_B_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_B_BGEU = 3'b111;

  localparam int unsigned INSN_BYTES = 4;

  typedef struct packed {
    logic taken;
    logic illegal;
  } br_dir_t;

  // Encodings 010/011 are reserved: never taken, flagged illegal.
  function automatic br_dir_t br_decide(input logic [2:0] funct3, input logic eq,
                                        input logic slt, input logic ult);
    br_dir_t d;
    d.taken   = 1'b0;
    d.illegal = 1'b0;
    case (funct3)
      FUNCT3_B_BEQ:  d.taken = eq;
      FUNCT3_B_BNE:  d.taken = ~eq;
      FUNCT3_B_BLT:  d.taken = slt;
      FUNCT3_B_BGE:  d.taken = ~slt;
      FUNCT3_B_BLTU: d.taken = ult;
      FUNCT3_B_BGEU: d.taken = ~ult;
      default:       d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/otter_br_cmp.sv
// Combinational operand comparator: equality, signed and unsigned less-than, all derived
// from one XLEN+1 bit subtractor.
module otter_br_cmp #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            eq_o,
  output logic            slt_o,
  output logic            ult_o
);

  logic [XLEN:0] diff;

  assign diff  = {1'b0, a_i} - {1'b0, b_i};
  assign eq_o  = (diff[XLEN-1:0] == '0);
  // The extra top bit is the borrow out, i.e. a < b unsigned.
  assign ult_o = diff[XLEN];
  // With differing signs the negative operand is smaller; otherwise no overflow is possible.
  assign slt_o = (a_i[XLEN-1] != b_i[XLEN-1]) ? a_i[XLEN-1] : diff[XLEN-1];

endmodule

// File: rtl/otter_br_resolve_unit.sv
// Execute-stage branch/JALR resolution: direction, target, redirect PC, mispredict and
// alignment flags behind a valid/ready output register, plus saturating retire counters.
module otter_br_resolve_unit
  import otter_br_resolve_unit_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned ALIGN = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_is_jalr,
  input  logic [2:0]       i_funct3,
  input  logic [XLEN-1:0]  i_rs1,
  input  logic [XLEN-1:0]  i_rs2,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_imm,
  input  logic             i_pred_taken,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_taken,
  output logic [XLEN-1:0]  o_target,
  output logic [XLEN-1:0]  o_redirect_pc,
  output logic             o_mispredict,
  output logic             o_misaligned,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_mp_cnt
);

  logic eq, slt, ult;

  otter_br_cmp #(
    .XLEN(XLEN)
  ) u_cmp (
    .a_i  (i_rs1),
    .b_i  (i_rs2),
    .eq_o (eq),
    .slt_o(slt),
    .ult_o(ult)
  );

  br_dir_t         dir;
  logic            taken_c, illegal_c, mispredict_c, misaligned_c;
  logic [XLEN-1:0] jalr_sum, target_c, redirect_c;

  always_comb begin
    dir      = br_decide(i_funct3, eq, slt, ult);
    jalr_sum = i_rs1 + i_imm;
    if (i_is_jalr) begin
      taken_c   = 1'b1;
      illegal_c = 1'b0;
      target_c  = {jalr_sum[XLEN-1:1], 1'b0};
    end else begin
      taken_c   = dir.taken;
      illegal_c = dir.illegal;
      target_c  = i_pc + i_imm;
    end
    redirect_c   = taken_c ? target_c : (i_pc + XLEN'(INSN_BYTES));
    mispredict_c = taken_c ^ i_pred_taken;
    misaligned_c = taken_c & ((ALIGN == 4) ? (|target_c[1:0]) : target_c[0]);
  end

  logic             valid_q, valid_d;
  logic             accept, retire;
  logic             taken_q, mispredict_q, misaligned_q, illegal_q;
  logic [XLEN-1:0]  target_q, redirect_q;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;

  assign o_ready = ~valid_q | i_ready;
  assign accept  = i_valid & o_ready & ~i_flush;
  assign retire  = valid_q & i_ready;

  // A retire in a flush cycle still counts; flush only kills what would be held or loaded.
  always_comb begin
    valid_d = valid_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (retire) begin
      valid_d = 1'b0;
    end

    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (retire && (br_cnt_q != '1)) begin
      br_cnt_d = br_cnt_q + CNT_W'(1);
    end
    if (retire && mispredict_q && (mp_cnt_q != '1)) begin
      mp_cnt_d = mp_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q      <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
      target_q     <= '0;
      redirect_q   <= '0;
      br_cnt_q     <= '0;
      mp_cnt_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
      if (accept) begin
        taken_q      <= taken_c;
        mispredict_q <= mispredict_c;
        misaligned_q <= misaligned_c;
        illegal_q    <= illegal_c;
        target_q     <= target_c;
        redirect_q   <= redirect_c;
      end
    end
  end

  assign o_valid       = valid_q;
  assign o_taken       = taken_q;
  assign o_target      = target_q;
  assign o_redirect_pc = redirect_q;
  assign o_mispredict  = mispredict_q;
  assign o_misaligned  = misaligned_q;
  assign o_illegal     = illegal_q;
  assign o_br_cnt      = br_cnt_q;
  assign o_mp_cnt      = mp_cnt_q;

endmodule
